// File: rtl/rns_mod11_pkg.sv
// Shared definitions for the mod-11 RNS channel: one-hot residue type, FSM
// states, and the one-hot doubling/increment primitives used by the adders.
package rns_mod11_pkg;

  localparam int MOD11   = 11;
  localparam int OHC11_W = 11;

  typedef logic [OHC11_W-1:0] ohc11_t;

  localparam ohc11_t OHC11_ZERO = 11'b00000000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Doubling mod 11 is a pure wire permutation: residue j comes from residue
  // 6*j, since 6 is the inverse of 2 mod 11.
  function automatic ohc11_t ohc11_double(input ohc11_t a);
    ohc11_t d;
    for (int j = 0; j < OHC11_W; j++) begin
      d[j] = a[(6 * j) % MOD11];
    end
    return d;
  endfunction

  // +1 mod 11 is a left rotate; residue 10 wraps to residue 0.
  function automatic ohc11_t ohc11_inc(input ohc11_t a);
    return {a[OHC11_W-2:0], a[OHC11_W-1]};
  endfunction

endpackage

// File: rtl/ohc_11_step.sv
// One Horner step of the serial mod-11 encoder: acc_next = (2*acc + b) mod 11,
// with acc and acc_next in one-hot form. Purely combinational.
module ohc_11_step
  import rns_mod11_pkg::*;
(
  input  logic [OHC11_W-1:0] acc,
  input  logic               b,
  output logic [OHC11_W-1:0] acc_next
);

  logic [OHC11_W-1:0] dbl;

  assign dbl      = ohc11_double(acc);
  assign acc_next = b ? ohc11_inc(dbl) : dbl;

endmodule

// File: rtl/binary_to_ohc_11.sv
// Serial binary-to-one-hot mod-11 encoder: consumes one operand bit per clock,
// MSB first, and presents the residue as an 11-bit one-hot code.
module binary_to_ohc_11
  import rns_mod11_pkg::*;
#(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OHC11_W-1:0] out_ohc
);

  localparam int CNT_W = $clog2(W);

  state_t             state;
  logic [OHC11_W-1:0] acc;
  logic [OHC11_W-1:0] acc_next;
  logic [W-1:0]       shreg;
  logic [CNT_W-1:0]   cnt;

  ohc_11_step u_step (
    .acc      (acc),
    .b        (shreg[W-1]),
    .acc_next (acc_next)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= OHC11_ZERO;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            acc   <= OHC11_ZERO;
            cnt   <= CNT_W'(W - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          shreg <= {shreg[W-2:0], 1'b0};
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags are decoded straight from the state register, so reset
  // clears them asynchronously along with the FSM.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_ohc   = out_valid ? acc : '0;

endmodule

// File: tb/tb_binary_to_ohc_11.sv
// Self-checking bench for binary_to_ohc_11: expected one-hot residues are
// queued at operand acceptance and compared when the DUT presents a result.
module tb_binary_to_ohc_11;
  import rns_mod11_pkg::*;

  localparam int W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OHC11_W-1:0] out_ohc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OHC11_W-1:0] exp_q[$];

  binary_to_ohc_11 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ohc   (out_ohc)
  );

  always #5 clk = ~clk;

  function automatic logic [OHC11_W-1:0] model(input logic [W-1:0] x);
    int r;
    r = int'(x) % MOD11;
    return OHC11_W'(1) << r;
  endfunction

  function automatic logic [OHC11_W-1:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents x until accepted, then scrambles in_data to prove it is not re-sampled.
  task automatic accept(input logic [W-1:0] x);
    int n = 0;
    in_data  = x;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    exp_q.push_back(model(x));
  endtask

  // Edges from the accept edge until out_valid is seen; -1 when it never comes.
  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!out_valid && edges < 4 * W);
    if (!out_valid) edges = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ohc !== '0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_ohc=%b, required 1 0 0",
               in_ready, out_valid, out_ohc);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_single(input string name, input logic [W-1:0] x);
    int e;
    logic [OHC11_W-1:0] exp;
    out_ready = 1'b1;
    accept(x);
    wait_valid(e);
    exp = pop_exp();
    n_checks++;
    if (e !== W) begin
      n_fail++;
      $display("FAIL %s_latency: %0d edges, required %0d", name, e, W);
    end
    n_checks++;
    if (out_ohc !== exp) begin
      n_fail++;
      $display("FAIL %s_result: out_ohc=%b, required %b", name, out_ohc, exp);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ohc !== '0) begin
      n_fail++;
      $display("FAIL %s_return_idle: in_ready=%b out_valid=%b out_ohc=%b, required 1 0 0",
               name, in_ready, out_valid, out_ohc);
    end
  endtask

  task automatic test_back_to_back();
    int ops[3] = '{10, 11, 1234};
    int acc_cyc[3] = '{-100, -200, -300};
    int idx = 0;
    int nout = 0;
    logic rdy;
    logic [OHC11_W-1:0] exp;
    out_ready = 1'b1;
    in_data   = W'(ops[0]);
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 4 * (W + 2) && nout < 3; cyc++) begin
      rdy = in_ready;
      tick();
      if (rdy && idx < 3) begin
        acc_cyc[idx] = cyc;
        exp_q.push_back(model(W'(ops[idx])));
        idx++;
        if (idx < 3) in_data = W'(ops[idx]);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        exp = pop_exp();
        n_checks++;
        if (out_ohc !== exp) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: out_ohc=%b, required %b", nout, out_ohc, exp);
        end
        nout++;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (nout !== 3) begin
      n_fail++;
      $display("FAIL b2b_count: %0d results, required 3", nout);
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] !== W + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing_%0d: %0d cycles, required %0d", i,
                 acc_cyc[i] - acc_cyc[i-1], W + 2);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_stall();
    int e;
    logic [OHC11_W-1:0] exp;
    out_ready = 1'b0;
    accept(21);
    wait_valid(e);
    exp = pop_exp();
    n_checks++;
    if (e !== W) begin
      n_fail++;
      $display("FAIL stall_latency: %0d edges, required %0d", e, W);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_ohc !== exp || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: out_valid=%b out_ohc=%b in_ready=%b, required 1 %b 0",
                 i, out_valid, out_ohc, in_ready, exp);
      end
      if (i == 5) out_ready = 1'b1;
      tick();
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int e;
    logic seen;
    logic [OHC11_W-1:0] exp;
    out_ready = 1'b1;
    accept(100);
    repeat (7) tick();
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || out_ohc !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_abort: out_valid=%b out_ohc=%b in_ready=%b, required 0 0 1",
               out_valid, out_ohc, in_ready);
    end
    repeat (2) tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_pulse: stale out_valid seen=%b, required 0", seen);
    end
    accept(5);
    wait_valid(e);
    exp = pop_exp();
    n_checks++;
    if (e !== W || out_ohc !== exp) begin
      n_fail++;
      $display("FAIL midreset_next: edges=%0d out_ohc=%b, required %0d %b", e, out_ohc, W, exp);
    end
    tick();
  endtask

  task automatic test_random();
    int e;
    int k;
    logic [W-1:0] x;
    logic [OHC11_W-1:0] exp;
    for (int i = 0; i < 1000; i++) begin
      x = (i == 0) ? '0 : (i == 1) ? '1 : W'($urandom);
      out_ready = 1'b0;
      accept(x);
      wait_valid(e);
      exp = pop_exp();
      n_checks++;
      if (e !== W || out_ohc !== exp || !$onehot(out_ohc)) begin
        n_fail++;
        $display("FAIL rand_%0d: x=%0d edges=%0d out_ohc=%b, required %0d %b",
                 i, x, e, out_ohc, W, exp);
      end
      k = $urandom_range(0, 3);
      repeat (k) tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_ohc !== exp) begin
        n_fail++;
        $display("FAIL rand_hold_%0d: out_valid=%b out_ohc=%b, required 1 %b",
                 i, out_valid, out_ohc, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single("zero", 16'd0);
    test_single("ones", 16'hFFFF);
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/binary_to_ohc_11.md
Name: binary_to_ohc_11

Overview:
- Serial encoder: converts a W-bit unsigned binary operand into its residue modulo 11, in 11-bit one-hot code (OHC).
- Sits at the entry of the mod-11 RNS channel and feeds the one-hot modulo adders. It is the counterpart of the channel's OHC-to-binary decoder.
- Processes one input bit per clock, MSB first, using Horner's rule r = (2r + b) mod 11.
- The accumulator is held directly in one-hot form, so each step is a wire permutation plus a conditional rotate. No adder or comparator is needed.

Parameters:
- W, 16, width of the binary operand; legal range 4..32.
- CNT_W, $clog2(W), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operand present on in_data.
- in_ready  output  1  block can accept an operand.
- in_data  input  W  unsigned binary operand.
- out_valid  output  1  residue present on out_ohc.
- out_ready  input  1  downstream accepts the residue.
- out_ohc  output  11  residue; bit k set means residue = k.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, acc=11'b00000000001, shreg=0, cnt=0, out_valid=0, out_ohc=0. in_ready=1, because in_ready is decoded from state==IDLE.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On clock edge with in_valid=1: shreg<=in_data, acc<=11'b00000000001, cnt<=W-1, go to SHIFT.
  - SHIFT:
    - in_ready=0, out_valid=0.
    - Each edge:
      - b = shreg[W-1].
      - d[j] = acc[(6*j) mod 11] for j=0..10. This is doubling mod 11; 6 is 2^-1 mod 11.
      - acc <= b ? rotl1(d) : d, where rotl1 gives new[(j+1) mod 11] = d[j], with bit10 wrapping to bit0.
      - shreg <= shreg<<1.
      - cnt <= cnt-1.
    - On the edge where cnt==0, the last step is applied and the FSM goes to DONE.
  - DONE:
    - out_valid=1, out_ohc=acc; in_ready=0.
    - On edge with out_ready=1: go to IDLE.
    - out_ohc and out_valid hold stable while out_ready=0.
- Outputs:
  - out_ohc=11'b0 whenever out_valid=0.
  - out_ohc is always exactly one-hot when out_valid=1.
- Latency: out_valid rises exactly W edges after the input-accept edge.
- Throughput: one operand per W+2 cycles; no overlap. Acceptance happens only in IDLE, and in_valid is ignored in SHIFT and DONE.
- in_data is sampled only on the accept edge; later changes on in_data have no effect.
- Wrap-around: residue 10 doubled gives 9; rotl1 of bit10 gives bit0.
- Reset asserted mid-SHIFT or mid-DONE aborts immediately: the in-flight operand is lost and no out_valid pulse appears.
- out_ready high while not in DONE is ignored.

Decomposition:
- Package rns_mod11_pkg holds:
  - constants MOD11=11, OHC11_W=11, OHC11_ZERO=11'b00000000001;
  - state enum {IDLE, SHIFT, DONE};
  - functions ohc11_double and ohc11_inc, shared with the modulo adders.
- Sub-module ohc_11_step (combinational, inputs acc and b, output next acc) isolates the Horner step. It is reusable and separately checkable by exhaustive test: 11 accumulator states x 2 bit values = 22 vectors.

Test Plan:
- in_data=16'd0, out_ready=1 -> out_valid rises 16 edges after accept; out_ohc=11'b00000000001; returns to IDLE with in_ready=1.
- in_data=16'hFFFF (65535) -> out_ohc=11'b00100000000 (residue 8).
- Back-to-back operands 10, 11, 1234 with in_valid held high -> out_ohc = bit10, bit0, bit2 (1234 mod 11 = 2), in that order; each accept is W+2 cycles apart.
- Operand 21 (residue 10) with out_ready=0 for 5 cycles -> out_ohc=11'b10000000000 held stable, in_ready=0 throughout; handshake on the 6th cycle, then IDLE.
- Assert rst at the 8th SHIFT cycle of operand 100 -> out_valid=0 and out_ohc=0 immediately. After release, in_ready=1; next operand 5 yields bit5.
- Random operand sweep (1000 values, random out_ready stalls) against the reference model in_data % 11 -> every result matches and is one-hot.
